// File: rtl/sdt_initiator_if.sv
// sdt_initiator_if: command, SDT bus and response signals of the SDT initiator
interface sdt_initiator_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rd;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ack;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_is_read;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;
    logic                  spurious_ack;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rd_data, ack, rsp_ready,
        output cmd_ready, rd, wr, addr, wr_data, rsp_valid, rsp_is_read, rsp_rdata, rsp_timeout, spurious_ack
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rd_data, ack, rsp_ready,
        input  cmd_ready, rd, wr, addr, wr_data, rsp_valid, rsp_is_read, rsp_rdata, rsp_timeout, spurious_ack
    );
endinterface

// File: rtl/sdt_initiator.sv
// sdt_initiator: one-outstanding SDT bus initiator; SDT_INIT_TIMEOUT_EN adds an ack watchdog
module sdt_initiator #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            rst,
    sdt_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t state, state_nx;
    logic   accept, done, tmo;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

`ifdef SDT_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    // watchdog: REQ cycles already elapsed; the limit is hit in REQ cycle TIMEOUT_CYCLES
    always_ff @(posedge clk)
        wd_cnt <= (rst || state != REQ) ? '0 : wd_cnt + 1'b1;

    assign tmo = state == REQ && !bus.ack && wd_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
`endif

    assign bus.cmd_ready = state == IDLE;
    assign accept        = state == IDLE && bus.cmd_valid;
    assign done          = state == REQ && (bus.ack || tmo);

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // next-state: a completed or aborted request always passes through RSP
    always_comb begin
        state_nx = state;
        state_nx = accept ? REQ :
                   done ? RSP :
                   (state == RSP && bus.rsp_ready) ? IDLE : state;
    end

    // registered bus drive, response capture and sticky spurious-ack flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd           <= 1'b0;
            bus.wr           <= 1'b0;
            bus.addr         <= '0;
            bus.wr_data      <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_is_read  <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_timeout  <= 1'b0;
            bus.spurious_ack <= 1'b0;
        end else begin
            if (bus.ack && state != REQ)
                bus.spurious_ack <= 1'b1;
            if (accept) begin
                bus.rd      <= !bus.cmd_we;
                bus.wr      <= bus.cmd_we;
                bus.addr    <= bus.cmd_addr;
                bus.wr_data <= bus.cmd_we ? bus.cmd_wdata : '0;
            end
            if (done) begin
                bus.rd          <= 1'b0;
                bus.wr          <= 1'b0;
                bus.rsp_valid   <= 1'b1;
                bus.rsp_is_read <= bus.rd;
                bus.rsp_rdata   <= (bus.ack && bus.rd) ? bus.rd_data : '0;
                bus.rsp_timeout <= !bus.ack;
            end
            if (state == RSP && bus.rsp_ready)
                bus.rsp_valid <= 1'b0;
        end
    end
endmodule
